ppu_ap_chain_top: RTL

Next-generation HLS-style control wrapper for the posit processing unit. It implements full `ap_ctrl_chain` semantics in front of a pipelined PPU core: credit-based admission, in-order result buffering, and `ap_continue` backpressure. The core sits behind a generic valid-only interface, so any PPU pipeline depth can be attached. The block sits between the HLS-generated host logic and `ppu_top`.

---
 rtl/ppu_ap_chain_top.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ppu_ap_chain_top.sv
// ppu_ap_chain_top
// ----------------
// ap_ctrl_chain control wrapper placed between HLS host logic and a pipelined
// posit processing unit. Ops are admitted against a credit pool of DEPTH
// entries; results return from the core in issue order. Each returned result
// is parked in a small FIFO until the host consumes it with ap_continue.
//
// Ports
//   ap_clk, ap_rst_n        clock, synchronous active-low reset
//   ap_start, ppu_in1/2,    host op request with operands and opcode
//   ppu_op
//   ap_ready                op accepted this cycle when ap_start & ap_ready
//   ap_continue             host consumes head result when ap_done & ap_continue
//   ap_done, ppu_valid_o    head result valid (identical signals)
//   ppu_out                 head result, 0 when the buffer is empty
//   ap_idle                 nothing in flight and nothing buffered
//   core_in_valid_o         launch into the core (= accept)
//   core_operand1/2_o,      combinational pass-through of the operands/opcode
//   core_op_o
//   core_out_valid_i,       core result, one per launched op, in order
//   core_result_i
//   err_o                   sticky: core returned a result nobody asked for
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// the producer's valid (ap_start / ap_done) and the consumer's ready
// (ap_ready / ap_continue) are both high. ap_ready and ap_done depend only on
// registered state, never on ap_start or ap_continue, so there is no
// combinational path from the host's valid/ready back to ours.

module ppu_ap_chain_top #(
    parameter int WORD    = 32,
    parameter int OP_SIZE = 3,
    parameter int DEPTH   = 4
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               ap_start,
    input  logic [WORD-1:0]    ppu_in1,
    input  logic [WORD-1:0]    ppu_in2,
    input  logic [OP_SIZE-1:0] ppu_op,
    output logic               ap_ready,
    input  logic               ap_continue,
    output logic               ap_done,
    output logic               ppu_valid_o,
    output logic [WORD-1:0]    ppu_out,
    output logic               ap_idle,
    output logic               core_in_valid_o,
    output logic [WORD-1:0]    core_operand1_o,
    output logic [WORD-1:0]    core_operand2_o,
    output logic [OP_SIZE-1:0] core_op_o,
    input  logic               core_out_valid_i,
    input  logic [WORD-1:0]    core_result_i,
    output logic               err_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] LAST_PTR  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    logic [CW-1:0] inflight;
    logic [CW-1:0] count;
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic          err;

    logic [WORD-1:0] mem [DEPTH];

    logic [CW:0] credit_used;
    logic        accept;
    logic        ret_legal;
    logic        ret_spurious;
    logic        push;
    logic        pop;

    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ONE;
    endfunction

    // One extra bit so the sum of two CW-wide counters cannot wrap.
    assign credit_used  = {1'b0, inflight} + {1'b0, count};

    // Credits cover both ops still in the core and results waiting in the
    // FIFO, so a push can never find the FIFO full.
    assign ap_ready     = ap_rst_n & (credit_used < DEPTH_SUM);
    assign accept       = ap_start & ap_ready;

    // A return with nothing outstanding is a core/protocol fault: it is
    // flagged and the data dropped, leaving all bookkeeping untouched.
    assign ret_legal    = core_out_valid_i & (inflight != '0);
    assign ret_spurious = core_out_valid_i & (inflight == '0);
    assign push         = ret_legal;

    assign ap_done      = (count != '0);
    assign pop          = ap_done & ap_continue;

    assign ppu_valid_o     = ap_done;
    assign ppu_out         = ap_done ? mem[rd_ptr[AW-1:0]] : '0;
    assign ap_idle         = (inflight == '0) & (count == '0);
    assign err_o           = err;

    assign core_in_valid_o = accept;
    assign core_operand1_o = ppu_in1;
    assign core_operand2_o = ppu_in2;
    assign core_op_o       = ppu_op;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            inflight <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            err      <= 1'b0;
        end else begin
            case ({accept, ret_legal})
                2'b10:   inflight <= inflight + ONE;
                2'b01:   inflight <= inflight - ONE;
                default: ;
            endcase

            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: ;
            endcase

            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (ret_spurious) begin
                err <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; count gates visibility.
    always_ff @(posedge ap_clk) begin
        if (ap_rst_n && push) begin
            mem[wr_ptr[AW-1:0]] <= core_result_i;
        end
    end

endmodule
